mem_port_arbiter: RTL

Arbiter and sequencer for one single-ported unified memory shared by the instruction-fetch requester (PC/IM path) and the data-access requester (MEM stage, loads and stores). It accepts at most one transaction at a time. It drives the memory for a fixed read latency and returns the read data, or a write acknowledge, to the requester that won. It sits between the processor's fetch/MEM stages and the memory macro.

---
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// and data access. One transaction in flight at a time, fixed read latency.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise data has priority, with a starvation guard for fetch.
//
// state | meaning
// IDLE  | no transaction in flight; arbitrate on any request
// BUSY  | memory access in flight; latency counter running, no grants
// RESP  | pulse valid to the owner; may arbitrate a new grant back-to-back
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LAT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state_q, state_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic              owner_q, owner_d;      // 1 = data requester owns the access
    logic              we_q, we_d;            // owning access is a store
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic              last_d_q, last_d_d;    // 1 = data was granted last
`else
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    logic [STV_W-1:0]  starve_q, starve_d;
`endif
    logic              pick_if, pick_d;

    // Choose the winner; reset and BUSY suppress all grants.
    always_comb begin
        pick_if = 1'b0;
        pick_d  = 1'b0;
        if (!rst && (state_q != BUSY)) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (if_req && d_req) begin
                pick_d  = !last_d_q;
                pick_if = last_d_q;
            end else begin
                pick_d  = d_req;
                pick_if = if_req;
            end
`else
            if (d_req && !(if_req && (starve_q == STV_W'(STARVE_MAX)))) begin
                pick_d = 1'b1;
            end else if (if_req) begin
                pick_if = 1'b1;
            end
`endif
        end
    end

    // Next state, latency counting, read capture and memory command outputs.
    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        owner_d    = owner_q;
        we_d       = we_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d_d   = last_d_q;
`else
        starve_d   = starve_q;
`endif
        if_gnt    = pick_if;
        d_gnt     = pick_d;
        mem_en    = pick_if | pick_d;
        mem_we    = pick_d & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (pick_d) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (pick_if) begin
            mem_addr  = if_addr;
        end
        if_valid = !rst && (state_q == RESP) && !owner_q;
        d_valid  = !rst && (state_q == RESP) && owner_q;

        case (state_q)
            BUSY: begin
                if (lat_cnt_q == LAT_W'(MEM_LAT)) begin
                    state_d = RESP;
                    if (owner_q) begin
                        if (!we_q) d_rdata_d = mem_rdata;
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pick_if || pick_d) begin
            state_d   = BUSY;
            lat_cnt_d = LAT_W'(1);
            owner_d   = pick_d;
            we_d      = pick_d & d_we;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_d  = pick_d;
`else
            if (pick_d && if_req) begin
                if (starve_q != STV_W'(STARVE_MAX)) starve_d = starve_q + 1'b1;
            end else begin
                starve_d = '0;
            end
`endif
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lat_cnt_q  <= '0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q   <= 1'b0;
`else
            starve_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q   <= last_d_d;
`else
            starve_q   <= starve_d;
`endif
        end
    end

    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule
